// File: rtl/hazard_scoreboard_if.sv
// Decode/writeback bundle of the hazard scoreboard.
//   master : decode and writeback stages. They drive the instruction and
//            writeback fields and receive stall/issue and the status.
//   slave  : the scoreboard itself.
// Signals:
//   idValid, idReg1Address, idReg2Address, idDestAddress,
//   idUsesR1, idUsesR2, idWritesDest    decode-stage instruction
//   exFlush                             taken branch squashes decode
//   wbValid, wbAddress                  writeback commit
//   stall, issue                        combinational decode control
//   busyMask, inFlight, underflowError  registered scoreboard status
interface hazard_scoreboard_if #(
   parameter int REGNUM       = 16,
   parameter int ADDRESSWIDTH = 4,
   parameter int COUNTWIDTH   = 2
);
   logic                               idValid;
   logic [ADDRESSWIDTH-1:0]            idReg1Address;
   logic [ADDRESSWIDTH-1:0]            idReg2Address;
   logic [ADDRESSWIDTH-1:0]            idDestAddress;
   logic                               idUsesR1;
   logic                               idUsesR2;
   logic                               idWritesDest;
   logic                               exFlush;
   logic                               wbValid;
   logic [ADDRESSWIDTH-1:0]            wbAddress;
   logic                               stall;
   logic                               issue;
   logic [REGNUM-1:0]                  busyMask;
   logic [ADDRESSWIDTH+COUNTWIDTH-1:0] inFlight;
   logic                               underflowError;

   modport master (
      output idValid, idReg1Address, idReg2Address, idDestAddress,
             idUsesR1, idUsesR2, idWritesDest, exFlush, wbValid, wbAddress,
      input  stall, issue, busyMask, inFlight, underflowError
   );

   modport slave (
      input  idValid, idReg1Address, idReg2Address, idDestAddress,
             idUsesR1, idUsesR2, idWritesDest, exFlush, wbValid, wbAddress,
      output stall, issue, busyMask, inFlight, underflowError
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// Issue controller for the decode stage.
// Each architectural register has a saturating pending-write counter.
// Decode stalls while a source is still pending or while the destination
// counter is full. A taken-branch flush squashes the decode instruction,
// and writebacks release their counts.
// Ports:
//   clock : system clock
//   reset : synchronous, active-high; it wins over every update
//   sb    : hazard_scoreboard_if.slave (decode, writeback, status)
module hazard_scoreboard #(
   parameter int REGNUM       = 16,
   parameter int ADDRESSWIDTH = 4,
   parameter int COUNTWIDTH   = 2,
   parameter int PCREG        = 15
) (
   input  logic                 clock,
   input  logic                 reset,
   hazard_scoreboard_if.slave   sb
);
   localparam int IFW = ADDRESSWIDTH + COUNTWIDTH;
   localparam logic [ADDRESSWIDTH-1:0] PC_ADDR = ADDRESSWIDTH'(PCREG);
   localparam logic [COUNTWIDTH-1:0]   CNT_MAX = '1;
   localparam logic [COUNTWIDTH-1:0]   CNT_ONE = COUNTWIDTH'(1);

   logic [COUNTWIDTH-1:0] pending_count [REGNUM];
   logic [IFW-1:0]        in_flight;
   logic                  underflow_error;

   logic [COUNTWIDTH-1:0] cnt_src1, cnt_src2, cnt_dest, cnt_wb;
   logic                  src1_hazard, src2_hazard, struct_hazard;
   logic                  stall_int, issue_int;
   logic                  inc_req, dec_req, same_reg, wb_underflow;
   logic                  inc_apply, dec_apply;

   assign cnt_src1 = pending_count[sb.idReg1Address];
   assign cnt_src2 = pending_count[sb.idReg2Address];
   assign cnt_dest = pending_count[sb.idDestAddress];
   assign cnt_wb   = pending_count[sb.wbAddress];

   // The register file writes on the falling edge. A writeback that
   // retires the last pending write of a source therefore satisfies the
   // read in the same cycle.
   assign src1_hazard = sb.idUsesR1 && (sb.idReg1Address != PC_ADDR) &&
                        (cnt_src1 != '0) &&
                        !(sb.wbValid && (sb.wbAddress == sb.idReg1Address) &&
                          (cnt_src1 == CNT_ONE));
   assign src2_hazard = sb.idUsesR2 && (sb.idReg2Address != PC_ADDR) &&
                        (cnt_src2 != '0) &&
                        !(sb.wbValid && (sb.wbAddress == sb.idReg2Address) &&
                          (cnt_src2 == CNT_ONE));

   // A full destination counter blocks issue. A writeback in the same
   // cycle earns no credit: the rule is deliberately conservative.
   assign struct_hazard = sb.idWritesDest && (sb.idDestAddress != PC_ADDR) &&
                          (cnt_dest == CNT_MAX);

   assign stall_int = sb.idValid && !sb.exFlush &&
                      (src1_hazard || src2_hazard || struct_hazard);
   assign issue_int = sb.idValid && !sb.exFlush && !stall_int;

   assign sb.stall          = stall_int;
   assign sb.issue          = issue_int;
   assign sb.inFlight       = in_flight;
   assign sb.underflowError = underflow_error;

   always_comb begin
      sb.busyMask = '0;
      for (int i = 0; i < REGNUM; i++) begin
         sb.busyMask[i] = (pending_count[i] != '0);
      end
   end

   assign inc_req      = issue_int && sb.idWritesDest && (sb.idDestAddress != PC_ADDR);
   assign dec_req      = sb.wbValid && (sb.wbAddress != PC_ADDR);
   assign same_reg     = (sb.idDestAddress == sb.wbAddress);
   assign wb_underflow = dec_req && (cnt_wb == '0);

   // An increment and a decrement on the same register cancel. If that
   // writeback is also an underflow, the count stays at zero.
   assign inc_apply = inc_req && !(dec_req && same_reg);
   assign dec_apply = dec_req && !wb_underflow && !(inc_req && same_reg);

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < REGNUM; i++) begin
            pending_count[i] <= '0;
         end
         in_flight       <= '0;
         underflow_error <= 1'b0;
      end else begin
         if (inc_apply) begin
            pending_count[sb.idDestAddress] <= cnt_dest + CNT_ONE;
         end
         if (dec_apply) begin
            pending_count[sb.wbAddress] <= cnt_wb - CNT_ONE;
         end
         in_flight <= in_flight + IFW'(inc_apply) - IFW'(dec_apply);
         if (wb_underflow) begin
            underflow_error <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   hazard_scoreboard_if #(.REGNUM(16), .ADDRESSWIDTH(4), .COUNTWIDTH(2)) sb ();

   hazard_scoreboard #(
      .REGNUM(16), .ADDRESSWIDTH(4), .COUNTWIDTH(2), .PCREG(15)
   ) dut (
      .clock(clock),
      .reset(reset),
      .sb(sb)
   );

   int checks = 0;
   int fails  = 0;

   // Reference state: outstanding writes per register and the sticky error.
   int cnt [16];
   bit uf;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic bit src_blocked(input bit uses, input int src, input bit wbv, input int wba);
      if (!uses || src == 15 || cnt[src] == 0) return 1'b0;
      if (wbv && wba == src && cnt[src] == 1) return 1'b0;
      return 1'b1;
   endfunction

   task automatic cyc(input bit v, input int r1, input int r2, input int d,
                      input bit u1, input bit u2, input bit wd, input bit fl,
                      input bit wbv, input int wba);
      bit blocked, exp_stall, exp_issue, inc, dec;
      int sum;
      logic [15:0] mask;
      sb.idValid       = v;
      sb.idReg1Address = 4'(r1);
      sb.idReg2Address = 4'(r2);
      sb.idDestAddress = 4'(d);
      sb.idUsesR1      = u1;
      sb.idUsesR2      = u2;
      sb.idWritesDest  = wd;
      sb.exFlush       = fl;
      sb.wbValid       = wbv;
      sb.wbAddress     = 4'(wba);
      #1;
      blocked = src_blocked(u1, r1, wbv, wba) || src_blocked(u2, r2, wbv, wba) ||
                (wd && d != 15 && cnt[d] == 3);
      exp_stall = v && !fl && blocked;
      exp_issue = v && !fl && !blocked;
      check("stall", 32'(sb.stall), 32'(exp_stall));
      check("issue", 32'(sb.issue), 32'(exp_issue));
      @(posedge clock);
      inc = exp_issue && wd && d != 15;
      dec = wbv && wba != 15;
      if (dec && cnt[wba] == 0) begin
         uf = 1'b1;
         if (inc && d == wba) inc = 1'b0;
      end else if (dec) begin
         cnt[wba]--;
      end
      if (inc) cnt[d]++;
      #1;
      sum  = 0;
      mask = '0;
      for (int i = 0; i < 16; i++) begin
         sum += cnt[i];
         mask[i] = (cnt[i] != 0);
      end
      check("busyMask", 32'(sb.busyMask), 32'(mask));
      check("inFlight", 32'(sb.inFlight), 32'(sum));
      check("underflowError", 32'(sb.underflowError), 32'(uf));
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      sb.idValid = 0; sb.exFlush = 0; sb.wbValid = 0;
      sb.idUsesR1 = 0; sb.idUsesR2 = 0; sb.idWritesDest = 0;
      @(posedge clock);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 16; i++) cnt[i] = 0;
      uf = 1'b0;
   endtask

   initial begin
      int pend [$];
      bit wbv;
      int wba;
      reset = 1'b1;
      sb.idValid = 0; sb.idReg1Address = 0; sb.idReg2Address = 0; sb.idDestAddress = 0;
      sb.idUsesR1 = 0; sb.idUsesR2 = 0; sb.idWritesDest = 0;
      sb.exFlush = 0; sb.wbValid = 0; sb.wbAddress = 0;
      @(posedge clock);
      #1;
      do_reset();

      // Reset state, then the first writer to r5 (issue, then busy bit 5).
      cyc(1, 3, 4, 5, 1, 1, 1, 0, 0, 0);
      check("busy_r5_after_issue", 32'(sb.busyMask), 32'h0020);

      // A reader of r5 stalls until the same-cycle writeback bypass.
      cyc(1, 5, 0, 0, 1, 0, 0, 0, 0, 0);
      cyc(1, 5, 0, 0, 1, 0, 0, 0, 0, 0);
      cyc(1, 5, 0, 0, 1, 0, 0, 0, 1, 5);

      // Saturation on r2: three writers, the fourth waits for a release.
      cyc(1, 0, 0, 2, 0, 0, 1, 0, 0, 0);
      cyc(1, 0, 0, 2, 0, 0, 1, 0, 0, 0);
      cyc(1, 0, 0, 2, 0, 0, 1, 0, 0, 0);
      cyc(1, 0, 0, 2, 0, 0, 1, 0, 0, 0);
      cyc(1, 0, 0, 2, 0, 0, 1, 0, 1, 2);
      cyc(1, 0, 0, 2, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 2);

      // r7: an issue and a writeback in the same cycle leave the count at 1.
      cyc(1, 0, 0, 7, 0, 0, 1, 0, 0, 0);
      cyc(1, 0, 0, 7, 0, 0, 1, 0, 1, 7);

      // A flush beats the source hazard on r7, and nothing is counted.
      cyc(1, 7, 7, 7, 1, 1, 1, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 7);

      // Underflow on r9 is sticky until reset.
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
      idle();
      cyc(1, 1, 2, 3, 1, 1, 1, 0, 0, 0);
      do_reset();
      idle();

      // The PC alias is neither tracked nor a source of stalls.
      cyc(1, 15, 15, 15, 1, 1, 1, 0, 0, 0);
      cyc(1, 15, 15, 15, 1, 1, 1, 0, 0, 0);
      cyc(1, 15, 0, 0, 1, 0, 0, 0, 0, 0);

      // Random traffic. Writebacks only target registers that have
      // outstanding writes. A reset falls midway through the run.
      for (int n = 0; n < 400; n++) begin
         if (n == 200) do_reset();
         pend.delete();
         for (int i = 0; i < 16; i++) if (cnt[i] > 0) pend.push_back(i);
         wbv = (pend.size() > 0) && ($urandom_range(0, 2) != 0);
         wba = wbv ? pend[$urandom_range(0, pend.size() - 1)] : int'($urandom_range(0, 15));
         cyc($urandom_range(0, 3) != 0,
             $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
             wbv, wba);
      end

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule
